// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus addresses,
// STATUS register bit positions and the serial engine state encoding.
package uart_pkg;

  localparam logic [31:0] UART_DATA_ADDR   = 32'hFFFF_0080;
  localparam logic [31:0] UART_STATUS_ADDR = 32'hFFFF_0084;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'hFFFF_0088;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_PENDING   = 4;
  localparam int STAT_INT_EN    = 5;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Parameterised synchronous FIFO with occupancy count; pushes while full are
// ignored, pops while empty are ignored. dout shows the head entry.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: store-fed byte FIFO, bit-serial 8N1 engine, frame-done interrupt.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before STOP (11-bit frames).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd_data,
  output logic        UARTAddress,
  output logic        UARTInterrupt,
  output logic        tx
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              int_en_q, int_en_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              hit_data, hit_status, hit_ctrl;
  logic              push, ctrl_wr, cnt_end, frame_done;
  logic              fifo_pop, fifo_empty, fifo_full;
  logic [7:0]        fifo_dout;
  logic [FCNT_W-1:0] fifo_count;
  logic [31:0]       status;
  logic              unused_data;

  assign hit_data    = (address == UART_DATA_ADDR);
  assign hit_status  = (address == UART_STATUS_ADDR);
  assign hit_ctrl    = (address == UART_CTRL_ADDR);
  assign UARTAddress = hit_data | hit_status | hit_ctrl;
  assign push        = MemWrite & hit_data;
  assign ctrl_wr     = MemWrite & hit_ctrl;
  assign cnt_end     = (cnt_q == CNT_LAST);
  assign frame_done  = (state_q == STOP) && cnt_end;
  assign unused_data = ^data[31:8];

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .din   (data[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (cnt_end) state_d = DATA;
      DATA:  if (cnt_end && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_d = PARITY;
`else
        state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (cnt_end) state_d = STOP;
`endif
      STOP:  if (cnt_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and line output are derived from the next state so tx is a plain flop.
  always_comb begin
    cnt_d     = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    fifo_pop  = (state_d == START) && (state_q != START);
    if (state_q != IDLE) cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    if (fifo_pop) begin
      shift_d   = fifo_dout;
      bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^fifo_dout;
`endif
    end else if (state_q == DATA && cnt_end) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
    end
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // A frame completion outranks a same-cycle software clear of pending.
  always_comb begin
    int_en_d   = ctrl_wr ? data[0] : int_en_q;
    pending_d  = frame_done ? 1'b1 : ((ctrl_wr && data[1]) ? 1'b0 : pending_q);
    overflow_d = (push && fifo_full) ? 1'b1 : ((ctrl_wr && data[2]) ? 1'b0 : overflow_q);
    status                         = '0;
    status[STAT_EMPTY]             = fifo_empty;
    status[STAT_FULL]              = fifo_full;
    status[STAT_BUSY]              = (state_q != IDLE);
    status[STAT_OVERFLOW]          = overflow_q;
    status[STAT_PENDING]           = pending_q;
    status[STAT_INT_EN]            = int_en_q;
    status[STAT_COUNT_LSB +: 8]    = 8'(fifo_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      int_en_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      int_en_q   <= int_en_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign UARTInterrupt = pending_q & int_en_q;
  assign rd_data       = (MemRead && hit_status) ? status : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random bus traffic,
// compared every cycle against a frame-timer reference model of the transmitter.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * CPB;
  localparam logic [31:0] A_DATA   = 32'hFFFF_0080;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0084;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0088;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] rd_data;
  logic        UARTAddress, UARTInterrupt, tx;

  always #5 clk = ~clk;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .data          (data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .rd_data       (rd_data),
    .UARTAddress   (UARTAddress),
    .UARTInterrupt (UARTInterrupt),
    .tx            (tx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus a timer measuring position within the current frame.
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_elapsed;
  logic [7:0] m_cur;
  bit         m_ovf, m_pend, m_ien;

  task automatic model_reset();
    m_q.delete();
    m_active  = 0;
    m_elapsed = 0;
    m_cur     = '0;
    m_ovf     = 0;
    m_pend    = 0;
    m_ien     = 0;
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_elapsed / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (NBITS == 11 && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_q.size() == 0);
    s[1]     = (m_q.size() == DEPTH);
    s[2]     = m_active;
    s[3]     = m_ovf;
    s[4]     = m_pend;
    s[5]     = m_ien;
    s[15:8]  = 8'(m_q.size());
    return s;
  endfunction

  function automatic bit frame_ends_next();
    return m_active && (m_elapsed == FRAME_LEN - 1);
  endfunction

  // Advance the model by one clock edge using the bus values present at that edge.
  task automatic model_step();
    bit done_now, start_new;
    int pre_size;
    if (reset) begin
      model_reset();
      return;
    end
    pre_size  = m_q.size();
    done_now  = frame_ends_next();
    start_new = (pre_size > 0) && (!m_active || done_now);
    if (start_new) begin
      m_cur     = m_q.pop_front();
      m_active  = 1;
      m_elapsed = 0;
    end else if (done_now) begin
      m_active = 0;
    end else if (m_active) begin
      m_elapsed++;
    end
    if (MemWrite && address == A_DATA) begin
      if (pre_size == DEPTH) m_ovf = 1;
      else m_q.push_back(data[7:0]);
    end
    if (MemWrite && address == A_CTRL) begin
      m_ien = data[0];
      if (data[1]) m_pend = 0;
      if (data[2]) m_ovf = 0;
    end
    if (done_now) m_pend = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tx", tx, exp_tx());
    check("irq", UARTInterrupt, m_pend & m_ien);
    address  = A_STATUS;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    check("status", rd_data, exp_status());
    check("status_hit", UARTAddress, 1);
    address = '0;
    MemRead = 1'b0;
    data    = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    data     = d;
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    cycle();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((m_active || m_q.size() > 0) && i < budget) begin
      cycle();
      i++;
    end
    repeat (2) cycle();
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("drain_idle_busy", rd_data[2], 0);
    check("drain_idle_count", rd_data[15:8], 0);
    address = '0;
    MemRead = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] seen;
  bit         hit;
  int         r;

  initial begin
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("reset_tx", tx, 1);
    check("reset_irq", UARTInterrupt, 0);
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("reset_status", rd_data, 32'h0000_0001);
    address = '0;
    MemRead = 1'b0;

    // Single byte 0xA5: line pattern sampled once per bit.
    bus_write(A_DATA, 32'h0000_00A5);
    seen = '0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        cycle();
        if (k == 1) seen[b] = tx;
      end
    end
`ifndef UART_TX_PARITY_EN
    check("a5_frame_bits", seen, 10'b11_0100_1010);
`endif
    drain(4 * FRAME_LEN);

    // Back-to-back frames with no idle gap.
    bus_write(A_DATA, 32'h41);
    bus_write(A_DATA, 32'h42);
    bus_write(A_DATA, 32'h43);
    drain(5 * FRAME_LEN);

    // Overflow: ten stores in a row into an idle transmitter.
    for (int i = 0; i < 10; i++) bus_write(A_DATA, 32'h60 + i);
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("ovf_count", rd_data[15:8], 8);
    check("ovf_full", rd_data[1], 1);
    check("ovf_flag", rd_data[3], 1);
    MemRead = 1'b0;
    bus_write(A_CTRL, 32'h4);
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("ovf_cleared", rd_data[3], 0);
    MemRead = 1'b0;
    drain(12 * FRAME_LEN);

    // Interrupt enable, frame-done, and set-wins over a same-edge clear.
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h3C);
    drain(3 * FRAME_LEN);
    check("irq_after_stop", UARTInterrupt, 1);
    bus_write(A_DATA, 32'h5A);
    hit = 0;
    for (int i = 0; i < 3 * FRAME_LEN && !hit; i++) begin
      if (frame_ends_next()) begin
        bus_write(A_CTRL, 32'h3);
        hit = 1;
      end else begin
        cycle();
      end
    end
    check("ctrl_on_stop_edge", hit, 1);
    check("irq_set_wins", UARTInterrupt, 1);
    bus_write(A_CTRL, 32'h3);
    check("irq_cleared", UARTInterrupt, 0);
    bus_write(A_CTRL, 32'h2);

    // Address decode and read gating.
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("dec_status_hit", UARTAddress, 1);
    check("dec_status_rd", rd_data, exp_status());
    address = 32'h1001_0000;
    #1;
    check("dec_miss_hit", UARTAddress, 0);
    check("dec_miss_rd", rd_data, 0);
    address = A_DATA;
    #1;
    check("dec_data_hit", UARTAddress, 1);
    check("dec_data_rd", rd_data, 0);
    address = A_CTRL;
    #1;
    check("dec_ctrl_rd", rd_data, 0);
    address = A_STATUS;
    MemRead = 1'b0;
    #1;
    check("dec_noread_rd", rd_data, 0);
    address = '0;

    // Random bus traffic, including stores just outside the window.
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      bus_write(A_DATA, $urandom);
      else if (r < 15) bus_write(A_CTRL, 32'($urandom_range(0, 7)));
      else if (r < 18) bus_write(32'hFFFF_008C, $urandom);
      else if (r < 20) bus_write(32'hFFFF_0084, $urandom);
      else             cycle();
    end
    bus_write(A_CTRL, 32'h6);
    drain(10 * FRAME_LEN);

    // Reset asserted in the middle of a data bit.
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h77);
    repeat (CPB + 3) cycle();
    check("pre_reset_tx_low", tx, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_tx", tx, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    address = A_STATUS;
    MemRead = 1'b1;
    #1;
    check("post_reset_status", rd_data, 32'h0000_0001);
    address = '0;
    MemRead = 1'b0;
    repeat (2 * FRAME_LEN) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
